// File: rtl/me_fs_ctrl.sv
// Full-search motion estimation sequencer: loads the template block, then the
// search window, then steps the address generator through every candidate.
module me_fs_ctrl #(
  parameter int TB_LEN   = 256,
  parameter int SW_LEN   = 4096,
  parameter int N_CAND   = 289,
  parameter int CAND_W   = 9,
  parameter int CNT_W    = 12,
  parameter int PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              clr,
  output logic              en_sw,
  output logic              en_tb,
  output logic              load_tb,
  output logic              load_sw,
  output logic              calc,
  output logic [CAND_W-1:0] cand_idx,
  output logic              cand_last,
  output logic              busy,
  output logic              done
);

  localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_TB, S_LOAD_SW, S_CALC, S_DRAIN, S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CAND_W-1:0]  r_cand;
  logic [DRN_W-1:0]   r_drain;

  logic w_busy, w_abort, w_tb_last, w_sw_last, w_cand_end, w_drain_end;

  assign w_busy      = (r_state != S_IDLE);
  assign w_abort     = abort && w_busy;
  assign w_tb_last   = (r_cnt == CNT_W'(TB_LEN - 1));
  assign w_sw_last   = (r_cnt == CNT_W'(SW_LEN - 1));
  assign w_cand_end  = (r_cand == CAND_W'(N_CAND - 1));
  assign w_drain_end = (r_drain == DRN_W'(PIPE_LAT - 1));

  // Outputs are decoded combinationally so the address generator acts on them
  // in the same cycle the sequencer decides.
  always_comb begin
    clr       = 1'b0;
    en_sw     = 1'b0;
    en_tb     = 1'b0;
    load_tb   = 1'b0;
    load_sw   = 1'b0;
    calc      = 1'b0;
    cand_last = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      S_IDLE:    clr = start;
      S_LOAD_TB: begin
        load_tb = 1'b1;
        en_tb   = in_valid;
        clr     = in_valid && w_tb_last;
      end
      S_LOAD_SW: begin
        load_sw = 1'b1;
        en_sw   = in_valid;
        clr     = in_valid && w_sw_last;
      end
      S_CALC: begin
        calc      = 1'b1;
        en_tb     = 1'b1;
        en_sw     = 1'b1;
        cand_last = w_tb_last;
      end
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
    if (w_abort) begin
      clr       = 1'b1;
      en_sw     = 1'b0;
      en_tb     = 1'b0;
      load_tb   = 1'b0;
      load_sw   = 1'b0;
      calc      = 1'b0;
      cand_last = 1'b0;
      done      = 1'b0;
    end
  end

  assign busy     = w_busy;
  assign cand_idx = r_cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_drain <= '0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_drain <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_LOAD_TB;
          r_cnt   <= '0;
        end
        S_LOAD_TB: if (in_valid) begin
          if (w_tb_last) begin
            r_state <= S_LOAD_SW;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOAD_SW: if (in_valid) begin
          if (w_sw_last) begin
            r_state <= S_CALC;
            r_cnt   <= '0;
            r_cand  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // TB address wraps on its own at the candidate boundary; no clr needed.
        S_CALC: begin
          if (w_tb_last) begin
            r_cnt <= '0;
            if (w_cand_end) begin
              r_state <= S_DRAIN;
              r_drain <= '0;
            end else begin
              r_cand <= r_cand + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_drain_end) r_state <= S_DONE;
          else             r_drain <= r_drain + 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_fs_ctrl.sv
// Bench for me_fs_ctrl: a directed vector table, then scoreboarded job
// sequences checked cycle by cycle against a phase/beat-count model.
module tb_me_fs_ctrl;

  localparam int TB_LEN   = 4;
  localparam int SW_LEN   = 8;
  localparam int N_CAND   = 3;
  localparam int CAND_W   = 2;
  localparam int CNT_W    = 4;
  localparam int PIPE_LAT = 2;
  localparam int BUSY_CYC = TB_LEN + SW_LEN + N_CAND * TB_LEN + PIPE_LAT + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic clr, en_sw, en_tb, load_tb, load_sw, calc, cand_last, busy, done;
  logic [CAND_W-1:0] cand_idx;

  always #5 clk = ~clk;

  me_fs_ctrl #(
    .TB_LEN(TB_LEN), .SW_LEN(SW_LEN), .N_CAND(N_CAND),
    .CAND_W(CAND_W), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_valid(in_valid),
    .clr(clr), .en_sw(en_sw), .en_tb(en_tb), .load_tb(load_tb), .load_sw(load_sw),
    .calc(calc), .cand_idx(cand_idx), .cand_last(cand_last), .busy(busy), .done(done)
  );

  // {clr,en_sw,en_tb,load_tb,load_sw,calc,cand_last,busy,done,cand_idx}
  logic [10:0] w_got;
  assign w_got = {clr, en_sw, en_tb, load_tb, load_sw, calc, cand_last, busy, done, cand_idx};

  typedef struct packed {
    logic       r, s, a, v;
    logic [8:0] o;
    logic [1:0] c;
  } vec_t;

  vec_t tbl [16];
  logic [10:0] sb [$];
  int checks = 0, failures = 0;

  // model state: phase, beats/cycles in phase, last candidate shown
  int m_ph = 0, m_n = 0, m_cand = 0;
  int k, n_busy, n_done, done_at, n_clr, n_last, n_load, n_tb_beat, n_sw_beat;

  task automatic model(input logic r, s, a, v, output logic [10:0] e);
    logic cl, es, et, lt, ls, ca, la, bu, dn;
    int ce, nph;
    {cl, es, et, lt, ls, ca, la, bu, dn} = '0;
    ce  = m_cand;
    nph = m_ph;
    if (!r) begin
      m_ph = 0; m_n = 0; m_cand = 0;
      e = '0;
      return;
    end
    case (m_ph)
      0: if (s) begin cl = 1; nph = 1; m_n = 0; end
      1: begin
        lt = 1; et = v; bu = 1;
        if (v) begin
          if (m_n == TB_LEN - 1) begin cl = 1; nph = 2; m_n = 0; end
          else m_n++;
        end
      end
      2: begin
        ls = 1; es = v; bu = 1;
        if (v) begin
          if (m_n == SW_LEN - 1) begin cl = 1; nph = 3; m_n = 0; m_cand = 0; end
          else m_n++;
        end
      end
      3: begin
        ca = 1; es = 1; et = 1; bu = 1;
        ce = m_n / TB_LEN;
        la = ((m_n % TB_LEN) == TB_LEN - 1);
        m_cand = ce;
        m_n++;
        if (m_n == N_CAND * TB_LEN) begin nph = 4; m_n = 0; end
      end
      4: begin
        bu = 1; m_n++;
        if (m_n == PIPE_LAT) nph = 5;
      end
      default: begin bu = 1; dn = 1; nph = 0; end
    endcase
    if (a && m_ph != 0) begin
      {cl, es, et, lt, ls, ca, la, bu, dn} = 9'b100000010;
      nph = 0; m_n = 0; m_cand = 0;
    end
    m_ph = nph;
    e = {cl, es, et, lt, ls, ca, la, bu, dn, 2'(ce)};
  endtask

  task automatic clr_stats();
    k = 0; n_busy = 0; n_done = 0; done_at = 0; n_clr = 0;
    n_last = 0; n_load = 0; n_tb_beat = 0; n_sw_beat = 0;
  endtask

  task automatic cyc(input logic r, s, a, v);
    logic [10:0] e, x;
    @(negedge clk);
    rst_n = r; start = s; abort = a; in_valid = v;
    k++;
    #1;
    model(r, s, a, v, e);
    sb.push_back(e);
    x = sb.pop_front();
    checks++;
    if (w_got !== x) begin
      failures++;
      $display("FAIL cycle k=%0d outputs got=%b exp=%b (clr,en_sw,en_tb,ld_tb,ld_sw,calc,last,busy,done,idx)",
               k, w_got, x);
    end
    if (busy) n_busy++;
    if (done) begin n_done++; done_at = k; end
    if (clr) n_clr++;
    if (cand_last) n_last++;
    if (load_tb || load_sw) n_load++;
    if (en_tb && load_tb) n_tb_beat++;
    if (en_sw && load_sw) n_sw_beat++;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  initial begin
    tbl[0]  = '{r:1'b0, s:1'b0, a:1'b0, v:1'b0, o:9'b000000000, c:2'd0};
    tbl[1]  = '{r:1'b1, s:1'b0, a:1'b0, v:1'b0, o:9'b000000000, c:2'd0};
    tbl[2]  = '{r:1'b1, s:1'b1, a:1'b1, v:1'b0, o:9'b100000000, c:2'd0};
    tbl[3]  = '{r:1'b1, s:1'b0, a:1'b0, v:1'b1, o:9'b001100010, c:2'd0};
    tbl[4]  = '{r:1'b1, s:1'b0, a:1'b0, v:1'b0, o:9'b000100010, c:2'd0};
    tbl[5]  = '{r:1'b1, s:1'b0, a:1'b1, v:1'b1, o:9'b100000010, c:2'd0};
    tbl[6]  = '{r:1'b1, s:1'b0, a:1'b1, v:1'b0, o:9'b000000000, c:2'd0};
    tbl[7]  = '{r:1'b1, s:1'b1, a:1'b0, v:1'b0, o:9'b100000000, c:2'd0};
    tbl[8]  = '{r:1'b1, s:1'b0, a:1'b0, v:1'b1, o:9'b001100010, c:2'd0};
    tbl[9]  = '{r:1'b1, s:1'b0, a:1'b0, v:1'b1, o:9'b001100010, c:2'd0};
    tbl[10] = '{r:1'b1, s:1'b0, a:1'b0, v:1'b1, o:9'b001100010, c:2'd0};
    tbl[11] = '{r:1'b1, s:1'b0, a:1'b0, v:1'b1, o:9'b101100010, c:2'd0};
    tbl[12] = '{r:1'b1, s:1'b0, a:1'b0, v:1'b0, o:9'b000010010, c:2'd0};
    tbl[13] = '{r:1'b1, s:1'b0, a:1'b0, v:1'b1, o:9'b010010010, c:2'd0};
    tbl[14] = '{r:1'b1, s:1'b0, a:1'b1, v:1'b1, o:9'b100000010, c:2'd0};
    tbl[15] = '{r:1'b1, s:1'b0, a:1'b0, v:1'b0, o:9'b000000000, c:2'd0};

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst_n = tbl[i].r; start = tbl[i].s; abort = tbl[i].a; in_valid = tbl[i].v;
      #1;
      checks++;
      if (w_got !== {tbl[i].o, tbl[i].c}) begin
        failures++;
        $display("FAIL vec%0d got=%b exp=%b", i, w_got, {tbl[i].o, tbl[i].c});
      end
    end

    // reset, then idle
    clr_stats();
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    chk("idle_busy", n_busy, 0);

    // full job, in_valid held high
    clr_stats();
    cyc(1, 1, 0, 1);
    for (int i = 0; i < 29; i++) cyc(1, 0, 0, 1);
    chk("full_busy", n_busy, BUSY_CYC);
    chk("full_done_at", done_at, BUSY_CYC + 1);
    chk("full_done_cnt", n_done, 1);
    chk("full_clr_cnt", n_clr, 3);
    chk("full_last_cnt", n_last, N_CAND);

    // in_valid toggling during the loads
    clr_stats();
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 45; i++) cyc(1, 0, 0, logic'(i % 2));
    chk("tog_load_cyc", n_load, 24);
    chk("tog_tb_beats", n_tb_beat, TB_LEN);
    chk("tog_sw_beats", n_sw_beat, SW_LEN);
    chk("tog_done_cnt", n_done, 1);

    // abort on the third CALC cycle, then a clean job
    clr_stats();
    cyc(1, 1, 0, 1);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 1);
    chk("abort_pre_calc", int'(calc), 1);
    cyc(1, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);
    chk("abort_no_done", n_done, 0);
    clr_stats();
    cyc(1, 1, 0, 1);
    for (int i = 0; i < 29; i++) cyc(1, 0, 0, 1);
    chk("post_abort_busy", n_busy, BUSY_CYC);
    chk("post_abort_done", n_done, 1);

    // start during LOAD_SW and CALC is ignored
    clr_stats();
    cyc(1, 1, 0, 1);
    for (int i = 2; i <= 35; i++) cyc(1, logic'(i == 8 || i == 16), 0, 1);
    chk("restart_done_cnt", n_done, 1);
    chk("restart_busy", n_busy, BUSY_CYC);

    // reset on the 6th SW beat
    clr_stats();
    cyc(1, 1, 0, 1);
    for (int i = 0; i < TB_LEN + 5; i++) cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_mid_busy", int'(busy), 0);
    cyc(0, 0, 0, 1);
    clr_stats();
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1);
    chk("rst_after_busy", n_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
